sdcard_writer: RTL

- Write-direction companion to the SD card sector read path.
- Host fills a 512-byte sector buffer one byte per command, then issues a start-write with a sector address.
- The block then drives the write port of sd_controller: wr, din, ready_for_next_byte, ready, address.
- It feeds the buffered bytes on each controller request and reports busy/done/error back to the host.

---
 rtl/sdcard_pkg.sv | 34 +++
 rtl/sdcard_writer_if.sv | 25 ++
 rtl/sdcard_sector_buffer.sv | 34 +++
 rtl/sdcard_writer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/sdcard_pkg.sv
// ---------------------------------------------------------------------------
// sdcard_pkg
//   Shared types and constants for the SD card sector writer.
//   - cmd_t       : host command encoding
//   - wr_state_t  : writer FSM states
//   - SectorBytes : bytes per sector; IdxW / CntW are the buffer index and
//                   send counter widths (the counter needs one extra bit so
//                   it can hold exactly 512).
// ---------------------------------------------------------------------------
package sdcard_pkg;

    localparam int SectorBytes = 512;
    localparam int IdxW        = 9;
    localparam int CntW        = IdxW + 1;

    localparam logic [CntW-1:0] FullCnt = CntW'(SectorBytes);

    typedef enum logic [1:0] {
        CmdIdle       = 2'd0,
        CmdStartWrite = 2'd1,
        CmdPush       = 2'd2,
        CmdRewind     = 2'd3
    } cmd_t;

    typedef enum logic [2:0] {
        Init,
        Idle,
        Start,
        WaitAccept,
        Write,
        Finish
    } wr_state_t;

endpackage

// File: rtl/sdcard_writer_if.sv
// ---------------------------------------------------------------------------
// sdcard_writer_if
//   Write-port bundle between the sector writer and sd_controller.
//   master (writer)     : drives wr, din, address; samples ready, ready_for_next_byte
//   slave  (controller) : the reverse
// ---------------------------------------------------------------------------
interface sdcard_writer_if;

    logic        wr;
    logic [7:0]  din;
    logic [31:0] address;
    logic        ready_for_next_byte;
    logic        ready;

    modport master (
        output wr, din, address,
        input  ready_for_next_byte, ready
    );

    modport slave (
        input  wr, din, address,
        output ready_for_next_byte, ready
    );

endinterface

// File: rtl/sdcard_sector_buffer.sv
// ---------------------------------------------------------------------------
// sdcard_sector_buffer
//   512 x 8 simple dual-port RAM: one synchronous write port (host side) and
//   one synchronous read port (controller feed). Contents are not reset so
//   the array maps onto block RAM.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write byte
//   rd_addr : read address (registered read, one cycle latency)
//   rd_data : byte at rd_addr from the previous cycle
// ---------------------------------------------------------------------------
module sdcard_sector_buffer
    import sdcard_pkg::*;
(
    input  logic            clk,
    input  logic            wr_en,
    input  logic [IdxW-1:0] wr_addr,
    input  logic [7:0]      wr_data,
    input  logic [IdxW-1:0] rd_addr,
    output logic [7:0]      rd_data
);

    logic [7:0] mem [SectorBytes];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sdcard_writer.sv
// ---------------------------------------------------------------------------
// sdcard_writer
//   Host fills a 512-byte sector buffer one byte per command, then starts a
//   write; the block drives the sd_controller write port, feeding one byte per
//   rising edge of ready_for_next_byte, and reports busy/done/error.
//
//   clk, rst_n     : clock, asynchronous active-low reset
//   command        : 0 idle, 1 start write, 2 push data_in, 3 rewind index
//   sector_address : sector for command 1
//   data_in        : byte stored by command 2
//   buffer_index   : next host write position
//   busy           : initialising or writing; commands ignored while high
//   done           : one-cycle pulse on successful completion
//   error          : sticky timeout / short-transfer flag
//   ctrl           : write port to sd_controller (master side)
// ---------------------------------------------------------------------------
module sdcard_writer
    import sdcard_pkg::*;
#(
    parameter bit          Simulate         = 1'b0,
    parameter int unsigned TimeoutCycles    = 2_000_000,
    parameter int unsigned SimTimeoutCycles = 2_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      command,
    input  logic [31:0]     sector_address,
    input  logic [7:0]      data_in,
    output logic [IdxW-1:0] buffer_index,
    output logic            busy,
    output logic            done,
    output logic            error,
    sdcard_writer_if.master ctrl
);

    localparam int unsigned Limit    = Simulate ? SimTimeoutCycles : TimeoutCycles;
    localparam logic [31:0] LastTick = 32'(Limit - 1);

    wr_state_t       state, state_d;
    cmd_t            cmd;
    logic [CntW-1:0] send_cnt, send_cnt_d;
    logic [31:0]     timer, timer_d;
    logic            rfnb_q;
    logic            busy_d, done_d, error_d, wr_d;
    logic [7:0]      din_d;
    logic [31:0]     addr_d;
    logic [IdxW-1:0] idx_d;
    logic            active, timeout, rfnb_rise, push_en;
    logic [7:0]      rd_data;

    assign cmd       = cmd_t'(command);
    assign active    = (state == Start) || (state == WaitAccept) || (state == Write);
    assign timeout   = active && (timer == LastTick);
    assign rfnb_rise = ctrl.ready_for_next_byte && !rfnb_q;
    assign push_en   = (state == Idle) && (cmd == CmdPush);

    // The read port continuously prefetches buffer[send_cnt]. Request edges
    // are at least two cycles apart (the strobe must drop in between), so the
    // RAM output has caught up with each increment before the next edge.
    sdcard_sector_buffer u_buf (
        .clk     (clk),
        .wr_en   (push_en),
        .wr_addr (buffer_index),
        .wr_data (data_in),
        .rd_addr (send_cnt[IdxW-1:0]),
        .rd_data (rd_data)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= Init;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            ctrl.wr      <= 1'b0;
            ctrl.din     <= 8'h00;
            ctrl.address <= 32'h0;
            buffer_index <= '0;
            send_cnt     <= '0;
            timer        <= 32'h0;
            rfnb_q       <= 1'b0;
        end else begin
            state        <= state_d;
            busy         <= busy_d;
            done         <= done_d;
            error        <= error_d;
            ctrl.wr      <= wr_d;
            ctrl.din     <= din_d;
            ctrl.address <= addr_d;
            buffer_index <= idx_d;
            send_cnt     <= send_cnt_d;
            timer        <= timer_d;
            rfnb_q       <= ctrl.ready_for_next_byte;
        end
    end

    // Next-state logic; a timeout overrides every other transition.
    always_comb begin
        state_d = state;
        case (state)
            Init:       if (ctrl.ready)           state_d = Idle;
            Idle:       if (cmd == CmdStartWrite) state_d = Start;
            Start:      if (ctrl.ready)           state_d = WaitAccept;
            WaitAccept: if (!ctrl.ready)          state_d = Write;
            Write:      if (ctrl.ready)           state_d = Finish;
            Finish:                               state_d = Idle;
            default:                              state_d = Init;
        endcase
        if (timeout) state_d = Idle;
    end

    // Register next-values. A request edge coinciding with ready rising
    // still loads its byte because the Write branch handles both together.
    always_comb begin
        busy_d     = busy;
        done_d     = 1'b0;
        error_d    = error;
        wr_d       = 1'b0;
        din_d      = ctrl.din;
        addr_d     = ctrl.address;
        idx_d      = buffer_index;
        send_cnt_d = send_cnt;
        timer_d    = active ? timer + 32'd1 : timer;

        case (state)
            Init: if (ctrl.ready) busy_d = 1'b0;
            Idle: begin
                case (cmd)
                    CmdPush:   idx_d = buffer_index + 1'b1;
                    CmdRewind: idx_d = '0;
                    CmdStartWrite: begin
                        addr_d     = sector_address;
                        busy_d     = 1'b1;
                        error_d    = 1'b0;
                        send_cnt_d = '0;
                        timer_d    = 32'h0;
                    end
                    default: ;
                endcase
            end
            Start: wr_d = ctrl.ready;
            Write: begin
                if (rfnb_rise) begin
                    if (send_cnt < FullCnt) begin
                        din_d      = rd_data;
                        send_cnt_d = send_cnt + 1'b1;
                    end else begin
                        din_d = 8'hFF;
                    end
                end
            end
            Finish: begin
                busy_d = 1'b0;
                if (send_cnt == FullCnt) done_d  = 1'b1;
                else                     error_d = 1'b1;
            end
            default: ;
        endcase

        if (timeout) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            wr_d    = 1'b0;
        end
    end

endmodule
